// File: rtl/prng_pkg.sv
`default_nettype none
// prng_pkg: golden-ratio constants, FSM state type, xorshift step and range-map helpers.
// Helpers work on 64-bit containers and mask down to the requested width.
package prng_pkg;

  localparam logic [31:0] GOLDEN32 = 32'h9E3779B9;
  localparam logic [63:0] GOLDEN64 = 64'h9E3779B97F4A7C15;

  typedef enum logic [0:0] {
    WARM = 1'b0,
    RUN  = 1'b1
  } prng_state_e;

  function automatic logic [63:0] width_mask(input int unsigned w);
    return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

  // s must already be confined to w bits; each left shift is re-masked so the
  // right shift never pulls overflow bits back into the state.
  function automatic logic [63:0] xorshift_step(input logic [63:0] s,
                                                input int unsigned a,
                                                input int unsigned b,
                                                input int unsigned c,
                                                input int unsigned w);
    logic [63:0] m;
    logic [63:0] t1;
    logic [63:0] t2;
    m  = width_mask(w);
    t1 = (s ^ (s << a)) & m;
    t2 = t1 ^ (t1 >> b);
    return (t2 ^ (t2 << c)) & m;
  endfunction

  function automatic logic [63:0] range_map(input logic [63:0] s,
                                            input logic [63:0] lo,
                                            input logic [63:0] span,
                                            input int unsigned w);
    logic [63:0] m;
    logic [15:0] top;
    logic [79:0] prod;
    m    = width_mask(w);
    top  = 16'((s & m) >> (w - 16));
    prod = 80'(top) * 80'(span & m);
    return (64'(prod >> 16) + lo) & m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prng_xorshift_lane.sv
`default_nettype none
// prng_xorshift_lane: one channel's state register, zero-guarded seeding and xorshift step.
// Output is range-mapped when PRNG_RANGE_EN is defined, raw state otherwise.
module prng_xorshift_lane
  import prng_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned IDX        = 0,
  parameter int unsigned SHIFT_A    = 13,
  parameter int unsigned SHIFT_B    = 17,
  parameter int unsigned SHIFT_C    = 5,
  parameter logic [63:0] SEED       = 64'hDEADBEEF,
  parameter logic [63:0] RANGE_MIN  = 64'h0,
  parameter logic [63:0] RANGE_SPAN = 64'h00100001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_base_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] data_o
);

  localparam logic [63:0] C_GOLDEN = (WIDTH == 64) ? GOLDEN64 : {32'd0, GOLDEN32};
  localparam logic [63:0] C_MASK   = (WIDTH >= 64) ? {64{1'b1}} : ((64'd1 << WIDTH) - 64'd1);

  // An all-zero xorshift state is a fixed point, so it is replaced by 1.
  function automatic logic [WIDTH-1:0] lane_seed(input logic [63:0] base);
    logic [63:0] v;
    v = (base ^ (64'(IDX) * C_GOLDEN)) & C_MASK;
    return (v == 64'd0) ? WIDTH'(1) : WIDTH'(v);
  endfunction

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = lane_seed(64'(seed_base_i));
    end else if (step_i) begin
      state_d = WIDTH'(xorshift_step(64'(state_q), SHIFT_A, SHIFT_B, SHIFT_C, WIDTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= lane_seed(SEED);
    end else begin
      state_q <= state_d;
    end
  end

`ifdef PRNG_RANGE_EN
  assign data_o = WIDTH'(range_map(64'(state_q), RANGE_MIN, RANGE_SPAN, WIDTH));
`else
  logic unused_range;
  assign unused_range = ^{RANGE_MIN, RANGE_SPAN};
  assign data_o       = state_q;
`endif

endmodule
`default_nettype wire

// File: rtl/prng_xorshift_multi.sv
`default_nettype none
// prng_xorshift_multi: N_CH xorshift streams with warm-up, reseed and valid/ready output.
// Define PRNG_RANGE_EN to map each channel into [RANGE_MIN, RANGE_MIN+RANGE_SPAN).
module prng_xorshift_multi
  import prng_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned N_CH       = 4,
  parameter int unsigned SHIFT_A    = 13,
  parameter int unsigned SHIFT_B    = 17,
  parameter int unsigned SHIFT_C    = 5,
  parameter logic [63:0] SEED       = 64'hDEADBEEF,
  parameter int unsigned WARMUP     = 8,
  parameter logic [63:0] RANGE_MIN  = 64'h0,
  parameter logic [63:0] RANGE_SPAN = 64'h00100001
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reseed_valid,
  input  logic [WIDTH-1:0]      reseed_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_CH*WIDTH-1:0] out_data,
  output logic [15:0]           out_seq
);

  prng_state_e state_q;
  logic [7:0]  warm_cnt_q;
  logic [15:0] seq_q;
  logic        lane_step;

  // Warm-up steps unconditionally; in RUN only an accepted transfer advances.
  assign lane_step = !rst && !reseed_valid && ((state_q == WARM) || out_ready);

  always_ff @(posedge clk) begin
    if (rst || reseed_valid) begin
      warm_cnt_q <= 8'(WARMUP);
      seq_q      <= 16'd0;
      if (WARMUP == 0) begin
        state_q <= RUN;
      end else begin
        state_q <= WARM;
      end
    end else begin
      case (state_q)
        WARM: begin
          warm_cnt_q <= warm_cnt_q - 8'd1;
          if (warm_cnt_q == 8'd1) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (out_ready) begin
            seq_q <= seq_q + 16'd1;
          end
        end
      endcase
    end
  end

  assign out_valid = (state_q == RUN);
  assign out_seq   = seq_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    prng_xorshift_lane #(
      .WIDTH      (WIDTH),
      .IDX        (i),
      .SHIFT_A    (SHIFT_A),
      .SHIFT_B    (SHIFT_B),
      .SHIFT_C    (SHIFT_C),
      .SEED       (SEED),
      .RANGE_MIN  (RANGE_MIN),
      .RANGE_SPAN (RANGE_SPAN)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .load_i      (reseed_valid),
      .seed_base_i (reseed_data),
      .step_i      (lane_step),
      .data_o      (out_data[i*WIDTH +: WIDTH])
    );
  end

endmodule
`default_nettype wire

// File: doc/prng_xorshift_multi.md
# prng_xorshift_multi

Parametrised multi-channel xorshift pseudo-random generator that supersedes the single fixed-width block. It produces N_CH independent WIDTH-bit streams behind a valid/ready handshake, with a runtime reseed port, a warm-up phase that discards early outputs, and a compile-time range-mapping stage. It sits between the stimulus/noise consumers and any block that needs a seeded, reproducible random source.

## Interface
- WIDTH, 32: state and output width per channel; legal values are 32 and 64.
- N_CH, 4: number of channels, 1..8.
- SHIFT_A, 13: first left-shift amount.
- SHIFT_B, 17: right-shift amount.
- SHIFT_C, 5: second left-shift amount.
- SEED, 32'hDEADBEEF: reset seed for channel 0, zero-extended to WIDTH.
- WARMUP, 8: number of discarded steps after reset or reseed, 0..255.
- RANGE_MIN, 0: lower bound of the mapped output. Used only with PRNG_RANGE_EN.
- RANGE_SPAN, 32'h00100001: number of output values (max − min + 1). Used only with PRNG_RANGE_EN.
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- reseed_valid  in  1  request to load a new seed; a one-cycle pulse is sufficient.
- reseed_data  in  WIDTH  new seed for channel 0.
- out_valid  out  1  out_data holds a fresh sample.
- out_ready  in  1  the consumer accepts the sample.
- out_data  out  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- out_seq  out  16  count of completed transfers since the last reset or reseed.

## Operation
- Per-channel seed: seed_i = base ^ (i * GOLDEN), truncated to WIDTH.
  - GOLDEN is 32'h9E3779B9 for WIDTH=32 and 64'h9E3779B97F4A7C15 for WIDTH=64.
  - base is SEED on reset and reseed_data on a reseed.
  - Zero guard: if seed_i == 0, the channel loads 1 instead.
- Step, applied to every channel in parallel:
  - t1 = s ^ (s << SHIFT_A)
  - t2 = t1 ^ (t1 >> SHIFT_B)
  - s' = t2 ^ (t2 << SHIFT_C)
  - All arithmetic is truncated to WIDTH.
- FSM states are WARM and RUN.
  - rst loads all seeds, clears out_seq, and sets warm_cnt = WARMUP. The FSM goes to WARM, or directly to RUN if WARMUP == 0.
  - WARM: each cycle every channel steps and warm_cnt decrements. When warm_cnt == 1, the FSM moves to RUN.
  - RUN: out_valid = 1. A transfer (out_valid && out_ready) steps all channels and increments out_seq, which wraps from 0xFFFF to 0.
- Reseed: reseed_valid is accepted in any state and has priority over stepping. It loads new seeds, reloads warm_cnt, and clears out_seq; the FSM then goes to WARM, or RUN if WARMUP == 0.
  - A reseed during WARM restarts the warm-up.
  - If a transfer and a reseed occur in the same cycle, the transfer counts as completed for the consumer. The new seeds win, and out_seq becomes 0.
- rst asserted at any point overrides everything, including reseed_valid.

## Timing
- Reset values: out_valid = 0 (or 1 when WARMUP == 0), out_seq = 0, out_data = mapped seeds.
- out_data is combinational from the state registers, with no extra pipeline stage.
- out_valid first rises on the edge at which the WARMUP-th warm step completes.
- While out_valid && !out_ready, out_data and out_seq hold stable.
- Throughput in RUN: one sample per cycle with out_ready held high.
- Reseed to next valid: WARMUP edges, or 0 edges if WARMUP == 0 (valid on the cycle after the reseed edge).

## Configuration
- PRNG_RANGE_EN defined: each channel outputs RANGE_MIN + ((s[WIDTH-1 -: 16] * RANGE_SPAN) >> 16).
  - The product is WIDTH+16 bits wide.
  - The result is truncated to WIDTH.
  - The state itself is unaffected.
- PRNG_RANGE_EN undefined: out_data is the raw state s. The RANGE_* parameters are ignored, and no multiplier is built.

## Structure
- Package prng_pkg holds:
  - the GOLDEN constants for both widths,
  - the FSM state enum (WARM, RUN),
  - the function xorshift_step(s, a, b, c),
  - the function range_map.
- One sub-module, prng_xorshift_lane, holds a single channel's state register, zero guard, step logic and range map. The top level instantiates N_CH lanes and owns the FSM, warm_cnt, out_seq and the handshake.

## Test plan
- Raw step sequence:
  - Setup: WIDTH=32, WARMUP=0, PRNG_RANGE_EN undefined; reseed with 32'h1.
  - Channel 0 outputs 0x00000001, then 0x00042021, then 0x04080601 over successive transfers with out_ready high.
  - out_seq reads 0, 1, 2.
- Zero guard: reseed with 32'h0, WARMUP=0 → channel 0 out_data = 0x00000001. No channel is ever all-zero.
- Warm-up and backpressure:
  - Setup: WARMUP=8; release rst with out_ready low.
  - out_valid rises exactly 8 edges after reset release.
  - While out_ready stays low for 5 cycles, out_data and out_seq hold constant.
  - With WARMUP=2 after a reseed of 32'h1, the first valid sample is 0x04080601.
- Reseed collision:
  - Setup: in RUN with out_seq = 5, assert reseed_valid and out_ready in the same cycle.
  - The transfer completes, out_seq becomes 0, out_valid drops for WARMUP cycles, and the new sequence matches a fresh reseed.
- Range mapping:
  - Setup: PRNG_RANGE_EN defined, RANGE_MIN=0x10, RANGE_SPAN=0x100001, WARMUP=0.
  - A reseed of 32'h80000000 gives out = 0x00080010.
  - A reseed of 32'h1 gives out = 0x00000010.
- Reset mid-run: assert rst during WARM and again during RUN with out_seq = 3 → both return to the SEED-derived state with out_seq = 0. The sequence is identical to the one seen after power-up.
